// File: rtl/md_rotate_pkg.sv
// Shared constants, operation enumeration and default decoded-entry layout for
// the MD/MDS-format rotate decoder (primary opcode 30).
package md_rotate_pkg;

  localparam logic [5:0] OPCODE_ROTATE = 6'd30;

  // MD-form extended opcode lives in bits 27:29, MDS-form in bits 27:30
  localparam logic [2:0] XO_RLDICL = 3'd0;
  localparam logic [2:0] XO_RLDICR = 3'd1;
  localparam logic [2:0] XO_RLDIC  = 3'd2;
  localparam logic [2:0] XO_RLDIMI = 3'd3;
  localparam logic [3:0] XO_RLDCL  = 4'd8;
  localparam logic [3:0] XO_RLDCR  = 4'd9;

  typedef enum logic [2:0] {
    OP_RLDICL = 3'd0,
    OP_RLDICR = 3'd1,
    OP_RLDIC  = 3'd2,
    OP_RLDIMI = 3'd3,
    OP_RLDCL  = 3'd4,
    OP_RLDCR  = 3'd5
  } md_op_e;

  localparam int unsigned DEF_REG_W = 5;
  localparam int unsigned DEF_IMM_W = 6;
  localparam int unsigned DEF_TAG_W = 8;

  typedef struct packed {
    md_op_e                 op;
    logic [DEF_REG_W-1:0]   rs;
    logic [DEF_REG_W-1:0]   ra;
    logic [DEF_REG_W-1:0]   rb;
    logic [DEF_IMM_W-1:0]   imm1;
    logic [DEF_IMM_W-1:0]   imm2;
    logic                   rc;
    logic [DEF_TAG_W-1:0]   tag;
  } md_entry_t;

  // xo is bits 27:30; only meaningful for already-qualified MD or MDS encodings
  function automatic md_op_e md_op_from_xo(input logic [3:0] xo);
    md_op_e op;
    if (!xo[3]) op = md_op_e'({1'b0, xo[2:1]});
    else        op = xo[0] ? OP_RLDCR : OP_RLDCL;
    return op;
  endfunction

endpackage

// File: rtl/md_rotate_decoder_if.sv
// Instruction-in / decoded-entry-out handshake bundle of md_rotate_decoder.
interface md_rotate_decoder_if #(
  parameter int unsigned regWidth         = 5,
  parameter int unsigned immWidth         = 6,
  parameter int unsigned instructionWidth = 32,
  parameter int unsigned tagWidth         = 8
);
  logic                        enable_i;
  logic [0:instructionWidth-1] instruction_i;
  logic [tagWidth-1:0]         tag_i;
  logic                        stall_o;

  logic                        enable_o;
  logic                        ready_i;
  logic [2:0]                  op_o;
  logic [regWidth-1:0]         rs_o;
  logic [regWidth-1:0]         ra_o;
  logic [regWidth-1:0]         rb_o;
  logic [immWidth-1:0]         imm1_o;
  logic [immWidth-1:0]         imm2_o;
  logic                        rc_o;
  logic [tagWidth-1:0]         tag_o;

  modport slave (
    input  enable_i, instruction_i, tag_i, ready_i,
    output stall_o, enable_o, op_o, rs_o, ra_o, rb_o, imm1_o, imm2_o, rc_o, tag_o
  );

  modport master (
    output enable_i, instruction_i, tag_i, ready_i,
    input  stall_o, enable_o, op_o, rs_o, ra_o, rb_o, imm1_o, imm2_o, rc_o, tag_o
  );
endinterface

// File: rtl/md_decode_fifo.sv
// Generic synchronous FIFO of decoded entries; head entry is read combinationally
// from the storage array so it only changes on a pop or a write into an empty FIFO.
module md_decode_fifo
  import md_rotate_pkg::*;
#(
  parameter type         entry_t = md_entry_t,
  parameter int unsigned depth   = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  entry_t                 wdata_i,
  input  logic                   pop_i,
  output entry_t                 rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(depth):0] occupancy_o
);
  localparam int unsigned PTR_W = $clog2(depth);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(depth);

  entry_t           mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full_o      = (count == DEPTH_CNT);
  assign empty_o     = (count == '0);
  assign occupancy_o = count;
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;
  assign rdata_o     = mem[rd_ptr];

  // depth is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/md_rotate_decoder.sv
// Buffered decoder for opcode-30 MD/MDS rotate instructions: combinational field
// assembly feeding a FIFO, plus a saturating count of undefined extended opcodes.
module md_rotate_decoder
  import md_rotate_pkg::*;
#(
  parameter int unsigned opcodeWidth      = 6,
  parameter int unsigned regWidth         = 5,
  parameter int unsigned immWidth         = 6,
  parameter int unsigned instructionWidth = 32,
  parameter int unsigned tagWidth         = 8,
  parameter int unsigned fifoDepth        = 4,
  parameter int unsigned countWidth       = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  md_rotate_decoder_if.slave    bus,
  output logic [countWidth-1:0] illegalCount_o
);
  localparam int unsigned OCC_W     = $clog2(fifoDepth) + 1;
  localparam int unsigned RS_POS    = opcodeWidth;
  localparam int unsigned RA_POS    = RS_POS + regWidth;
  localparam int unsigned RB_POS    = RA_POS + regWidth;
  localparam int unsigned MB_POS    = RB_POS + immWidth - 1;
  localparam int unsigned MB_HI_POS = MB_POS + immWidth - 1;
  localparam int unsigned XO_POS    = MB_HI_POS + 1;
  localparam int unsigned SH_HI_POS = instructionWidth - 2;
  localparam int unsigned RC_POS    = instructionWidth - 1;

  typedef struct packed {
    md_op_e              op;
    logic [regWidth-1:0] rs;
    logic [regWidth-1:0] ra;
    logic [regWidth-1:0] rb;
    logic [immWidth-1:0] imm1;
    logic [immWidth-1:0] imm2;
    logic                rc;
    logic [tagWidth-1:0] tag;
  } entry_t;

  logic [0:instructionWidth-1] instr;
  entry_t                      dec_entry;
  entry_t                      head;
  logic                        is_rotate;
  logic                        is_md;
  logic                        is_mds;
  logic                        accept;
  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [OCC_W-1:0]            occupancy;

  assign instr = bus.instruction_i;

  always_comb begin
    dec_entry = '0;
    is_rotate = (instr[0 +: opcodeWidth] == opcodeWidth'(OPCODE_ROTATE));
    is_md     = is_rotate &&
                (instr[XO_POS +: 3] inside {XO_RLDICL, XO_RLDICR, XO_RLDIC, XO_RLDIMI});
    is_mds    = is_rotate && (instr[XO_POS +: 4] inside {XO_RLDCL, XO_RLDCR});

    dec_entry.op   = md_op_from_xo(instr[XO_POS +: 4]);
    dec_entry.rs   = instr[RS_POS +: regWidth];
    dec_entry.ra   = instr[RA_POS +: regWidth];
    dec_entry.rb   = instr[RB_POS +: regWidth];
    // sh shares bits 16:20 with rb; MDS forms take the shift from rb instead
    dec_entry.imm1 = is_md ? {instr[SH_HI_POS], instr[RB_POS +: immWidth-1]} : '0;
    dec_entry.imm2 = {instr[MB_HI_POS], instr[MB_POS +: immWidth-1]};
    dec_entry.rc   = instr[RC_POS];
    dec_entry.tag  = bus.tag_i;
  end

  assign accept = bus.enable_i & ~full;
  assign push   = accept & (is_md | is_mds);
  assign pop    = bus.enable_o & bus.ready_i;

  md_decode_fifo #(
    .entry_t (entry_t),
    .depth   (fifoDepth)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .wdata_i     (dec_entry),
    .pop_i       (pop),
    .rdata_o     (head),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occupancy)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      illegalCount_o <= '0;
    end else if (accept && is_rotate && !is_md && !is_mds && illegalCount_o != '1) begin
      illegalCount_o <= illegalCount_o + 1'b1;
    end
  end

  assign bus.stall_o  = (occupancy == OCC_W'(fifoDepth));
  assign bus.enable_o = ~empty;
  assign bus.op_o     = head.op;
  assign bus.rs_o     = head.rs;
  assign bus.ra_o     = head.ra;
  assign bus.rb_o     = head.rb;
  assign bus.imm1_o   = head.imm1;
  assign bus.imm2_o   = head.imm2;
  assign bus.rc_o     = head.rc;
  assign bus.tag_o    = head.tag;

endmodule

// File: tb/tb_md_rotate_decoder.sv
// Bench for md_rotate_decoder: directed scenarios plus randomized traffic against
// a queue-based reference model that decodes from instruction bit positions.
module tb_md_rotate_decoder;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ill_cnt;
  logic [1:0]  ill_cnt_sat;

  md_rotate_decoder_if bus ();
  md_rotate_decoder_if bus_sat ();

  md_rotate_decoder #(.fifoDepth(DEPTH)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .bus            (bus),
    .illegalCount_o (ill_cnt)
  );

  md_rotate_decoder #(.fifoDepth(DEPTH), .countWidth(2)) dut_sat (
    .clock_i        (clk),
    .reset_i        (rst),
    .bus            (bus_sat),
    .illegalCount_o (ill_cnt_sat)
  );

  assign bus_sat.enable_i      = bus.enable_i;
  assign bus_sat.instruction_i = bus.instruction_i;
  assign bus_sat.tag_i         = bus.tag_i;
  assign bus_sat.ready_i       = bus.ready_i;

  always #5 clk = ~clk;

  typedef struct {
    int unsigned op, rs, ra, rb, imm1, imm2, rc, tag;
  } exp_t;

  exp_t        q[$];
  int unsigned m_cnt;
  int unsigned m_cnt_sat;
  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned popped[$];

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // IBM bit numbering: bit 0 is the MSB of the 32-bit word
  function automatic int unsigned fld(input logic [31:0] w, input int unsigned lo, input int unsigned hi);
    int unsigned v;
    v = w;
    return (v >> (31 - hi)) & ((32'd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic logic [31:0] mk_md(input int unsigned xo, rs, ra, sh, mb, rc);
    return (32'd30 << 26) | (rs << 21) | (ra << 16) | ((sh % 32) << 11) | ((mb % 32) << 6)
         | ((mb / 32) << 5) | (xo << 2) | ((sh / 32) << 1) | rc;
  endfunction

  function automatic logic [31:0] mk_mds(input int unsigned xo4, rs, ra, rb, me, rc);
    return (32'd30 << 26) | (rs << 21) | (ra << 16) | (rb << 11) | ((me % 32) << 6)
         | ((me / 32) << 5) | (xo4 << 1) | rc;
  endfunction

  // Reference behaviour for one clock edge, using pre-edge state and current inputs
  task automatic model_edge();
    logic [31:0] w;
    bit          acc, pop;
    int unsigned xo3, xo4;
    exp_t        e;
    w   = bus.instruction_i;
    acc = bus.enable_i && (q.size() != DEPTH);
    pop = (q.size() != 0) && bus.ready_i;
    if (pop) void'(q.pop_front());
    if (acc && fld(w, 0, 5) == 30) begin
      xo3    = fld(w, 27, 29);
      xo4    = fld(w, 27, 30);
      e.rs   = fld(w, 6, 10);
      e.ra   = fld(w, 11, 15);
      e.rb   = fld(w, 16, 20);
      e.imm2 = fld(w, 26, 26) * 32 + fld(w, 21, 25);
      e.rc   = fld(w, 31, 31);
      e.tag  = bus.tag_i;
      if (xo3 <= 3) begin
        e.op   = xo3;
        e.imm1 = fld(w, 30, 30) * 32 + fld(w, 16, 20);
        q.push_back(e);
      end else if (xo4 == 8 || xo4 == 9) begin
        e.op   = xo4 - 4;
        e.imm1 = 0;
        q.push_back(e);
      end else begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
    end
  endtask

  task automatic check_all();
    chk("enable_o", bus.enable_o, q.size() != 0);
    chk("stall_o", bus.stall_o, q.size() == DEPTH);
    chk("illegal_cnt", ill_cnt, m_cnt);
    chk("illegal_cnt_sat", ill_cnt_sat, m_cnt_sat);
    if (q.size() != 0) begin
      chk("op_o", bus.op_o, q[0].op);
      chk("rs_o", bus.rs_o, q[0].rs);
      chk("ra_o", bus.ra_o, q[0].ra);
      chk("rb_o", bus.rb_o, q[0].rb);
      chk("imm1_o", bus.imm1_o, q[0].imm1);
      chk("imm2_o", bus.imm2_o, q[0].imm2);
      chk("rc_o", bus.rc_o, q[0].rc);
      chk("tag_o", bus.tag_o, q[0].tag);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Presents one instruction until accepted (bounded), then drops enable_i
  task automatic send(input logic [31:0] w, input int unsigned tag);
    bit acc;
    bus.enable_i      = 1'b1;
    bus.instruction_i = w;
    bus.tag_i         = 8'(tag);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = (q.size() != DEPTH);
      cycle();
    end
    if (!acc) chk("send_timeout", 0, 1);
    bus.enable_i = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst && bus.enable_o && bus.ready_i) popped.push_back(bus.tag_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bit          holding, acc;
    int unsigned waited;

    n_cmp = 0; n_err = 0; m_cnt = 0; m_cnt_sat = 0;
    bus.enable_i = 1'b0; bus.instruction_i = '0; bus.tag_i = '0; bus.ready_i = 1'b0;

    // Reset state
    #1;
    chk("rst_enable_o", bus.enable_o, 0);
    chk("rst_stall_o", bus.stall_o, 0);
    chk("rst_cnt", ill_cnt, 0);
    chk("rst_op_o", bus.op_o, 0);
    chk("rst_rs_o", bus.rs_o, 0);
    chk("rst_imm2_o", bus.imm2_o, 0);
    chk("rst_tag_o", bus.tag_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // rldicl r3,r4,5,10
    bus.ready_i = 1'b1;
    send(32'h78832A80, 8'h11);
    chk("t1_enable", bus.enable_o, 1);
    chk("t1_op", bus.op_o, 0);
    chk("t1_rs", bus.rs_o, 4);
    chk("t1_ra", bus.ra_o, 3);
    chk("t1_imm1", bus.imm1_o, 5);
    chk("t1_imm2", bus.imm2_o, 10);
    chk("t1_rc", bus.rc_o, 0);
    chk("t1_tag", bus.tag_o, 8'h11);
    cycle();

    // rldcr rb=7 me=33 Rc=1
    send(mk_mds(9, 2, 6, 7, 33, 1), 8'h12);
    chk("t2_op", bus.op_o, 5);
    chk("t2_rb", bus.rb_o, 7);
    chk("t2_imm1", bus.imm1_o, 0);
    chk("t2_imm2", bus.imm2_o, 33);
    chk("t2_rc", bus.rc_o, 1);
    cycle();

    // Fill with ready low, fifth held upstream, then drain in order
    bus.ready_i = 1'b0;
    popped.delete();
    for (int unsigned i = 0; i < 4; i++) send(mk_md(i, i, i + 1, 20 + i, 40 + i, i % 2), 8'h20 + i);
    chk("fill_stall", bus.stall_o, 1);
    bus.enable_i      = 1'b1;
    bus.instruction_i = mk_mds(8, 9, 10, 11, 12, 0);
    bus.tag_i         = 8'h24;
    cycle();
    cycle();
    chk("held_stall", bus.stall_o, 1);
    chk("held_head_tag", bus.tag_o, 8'h20);
    bus.ready_i = 1'b1;
    acc = 1'b0;
    waited = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = (q.size() != DEPTH);
      cycle();
      waited++;
    end
    chk("fifth_accept_cycles", waited, 2);
    bus.enable_i = 1'b0;
    for (int i = 0; i < 10 && bus.enable_o; i++) cycle();
    chk("drain_count", popped.size(), 5);
    for (int unsigned i = 0; i < 5 && i < popped.size(); i++) chk("drain_order", popped[i], 8'h20 + i);

    // Undefined XO (bits 27:30 = 12)
    w = (32'd30 << 26) | (32'd12 << 1);
    for (int i = 0; i < 3; i++) send(w, 8'h30);
    chk("ill3_cnt", ill_cnt, 3);
    chk("ill3_sat", ill_cnt_sat, 3);
    chk("ill3_enable", bus.enable_o, 0);
    for (int i = 0; i < 2; i++) send(w, 8'h31);
    chk("ill5_cnt", ill_cnt, 5);
    chk("ill5_sat", ill_cnt_sat, 3);

    // Foreign opcode
    send((32'd31 << 26) | 32'h0012_3456, 8'h40);
    chk("op31_enable", bus.enable_o, 0);
    chk("op31_cnt", ill_cnt, 5);

    // Mid-cycle reset with three entries buffered
    bus.ready_i = 1'b0;
    for (int unsigned i = 0; i < 3; i++) send(mk_md(1, 5, 6, 7, 8, 0), 8'h50 + i);
    chk("pre_rst_enable", bus.enable_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_enable", bus.enable_o, 0);
    chk("mid_rst_stall", bus.stall_o, 0);
    chk("mid_rst_tag", bus.tag_o, 0);
    chk("mid_rst_cnt", ill_cnt, 0);
    q.delete(); m_cnt = 0; m_cnt_sat = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.ready_i = 1'b1;
    send(mk_md(2, 1, 2, 63, 1, 1), 8'h60);
    chk("post_rst_enable", bus.enable_o, 1);
    chk("post_rst_tag", bus.tag_o, 8'h60);
    chk("post_rst_imm1", bus.imm1_o, 63);
    cycle();

    // Randomized traffic with upstream hold-on-stall
    holding = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!holding) begin
        bus.enable_i = ($urandom_range(0, 3) != 0);
        w = $urandom;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: begin w[31:26] = 6'd30; w[4] = 1'b0; end
          5, 6:          begin w[31:26] = 6'd30; w[4:2] = 3'b100; end
          7, 8:          begin w[31:26] = 6'd30; w[4:1] = 4'($urandom_range(10, 15)); end
          default:       w[31:26] = 6'($urandom_range(31, 63));
        endcase
        bus.instruction_i = w;
        bus.tag_i = 8'($urandom);
      end
      bus.ready_i = ($urandom_range(0, 2) != 0);
      holding = bus.enable_i && (q.size() == DEPTH);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
